// File: rtl/shift_operand_decoder_pkg.sv
// rtl/shift_operand_decoder_pkg.sv - shared constants and state type for the operand-2 decoder
//
// Purpose: shift-type encodings as the barrel shifter sees them, the
// instruction-class field values (instr[27:26]) and the decoder state enum.
package shift_operand_decoder_pkg;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] CLASS_DP  = 2'b00;
  localparam logic [1:0] CLASS_SDT = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RS_REQ = 2'd1,
    ST_RS_CAP = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

endpackage

// File: rtl/shift_operand_decoder_if.sv
// rtl/shift_operand_decoder_if.sv - decode, Rs register-file and shifter-side signals of the decoder
//
// Purpose: bundles the three handshake groups around the decoder.
// Ports (signals):
//   decode side  : instr_valid, instr_ready, instr
//   Rs read      : rs_read_en, rs_addr, rs_data (rs_data valid the cycle after rs_read_en)
//   shifter side : op_valid, op_ready, rm_addr, use_imm, imm_value, shiftType,
//                  shift_amt, rrx, op_illegal
// Modports: slave = the decoder, master = its surroundings (decode, regfile, shifter).
interface shift_operand_decoder_if #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
);

  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;

  logic              rs_read_en;
  logic [3:0]        rs_addr;
  logic [DATA_W-1:0] rs_data;

  logic              op_valid;
  logic              op_ready;
  logic [3:0]        rm_addr;
  logic              use_imm;
  logic [DATA_W-1:0] imm_value;
  logic [1:0]        shiftType;
  logic [AMT_W-1:0]  shift_amt;
  logic              rrx;
  logic              op_illegal;

  modport slave (
    input  instr_valid, instr, rs_data, op_ready,
    output instr_ready, rs_read_en, rs_addr,
    output op_valid, rm_addr, use_imm, imm_value, shiftType, shift_amt, rrx, op_illegal
  );

  modport master (
    output instr_valid, instr, rs_data, op_ready,
    input  instr_ready, rs_read_en, rs_addr,
    input  op_valid, rm_addr, use_imm, imm_value, shiftType, shift_amt, rrx, op_illegal
  );

endinterface

// File: rtl/shift_operand_decoder_shift_imm_normalize.sv
// rtl/shift_operand_decoder_shift_imm_normalize.sv - maps an immediate-shift (type, amt5) to shifter controls
//
// Purpose: applies the ARM zero-amount special cases of immediate shifts.
// Ports:
//   type_i [1:0]       shift type field instr[6:5]
//   amt5_i [4:0]       shift amount field instr[11:7]
//   type_o [1:0]       shift type for the shifter
//   amt_o  [AMT_W-1:0] effective shift amount
//   rrx_o              rotate-right-extended through carry
module shift_imm_normalize
  import shift_operand_decoder_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [1:0]       type_i,
  input  logic [4:0]       amt5_i,
  output logic [1:0]       type_o,
  output logic [AMT_W-1:0] amt_o,
  output logic             rrx_o
);

  always_comb begin
    type_o = type_i;
    amt_o  = AMT_W'(amt5_i);
    rrx_o  = 1'b0;
    if (amt5_i == 5'd0) begin
      case (type_i)
        // LSR #0 and ASR #0 encode a shift by 32
        SHIFT_LSR, SHIFT_ASR: amt_o = AMT_W'(32);
        // ROR #0 encodes RRX: a one-bit rotate through carry
        SHIFT_ROR: begin
          rrx_o = 1'b1;
          amt_o = AMT_W'(1);
        end
        default: amt_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_decoder.sv
// rtl/shift_operand_decoder.sv - decodes ARM operand-2 / offset fields into barrel-shifter controls
//
// Purpose: accepts an instruction from decode, registers the shifter controls
// and, for register-specified shifts, performs one Rs register-file read and
// captures Rs[AMT_W-1:0] as the shift amount before presenting the operand.
// Ports:
//   clk   rising-edge clock
//   reset synchronous active-high reset
//   bus   shift_operand_decoder_if.slave (decode, Rs read and shifter handshakes)
module shift_operand_decoder
  import shift_operand_decoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_operand_decoder_if.slave bus
);

  state_e            state_q, state_d;
  logic              use_imm_q, use_imm_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [1:0]        type_q, type_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic              rrx_q, rrx_d;
  logic              ill_q, ill_d;
  logic [3:0]        rm_q, rm_d;
  logic [3:0]        rs_q, rs_d;

  logic              instr_ready;
  logic              accept;

  logic              dec_use_imm;
  logic [DATA_W-1:0] dec_imm;
  logic [1:0]        dec_type;
  logic [AMT_W-1:0]  dec_amt;
  logic              dec_rrx;
  logic              dec_ill;
  logic              dec_is_rs;

  logic [1:0]        norm_type;
  logic [AMT_W-1:0]  norm_amt;
  logic              norm_rrx;

  // Condition, opcode and Rn/Rd fields play no part in operand-2 decode.
  logic unused_bits;
  assign unused_bits = ^{bus.instr[31:28], bus.instr[24:12], bus.rs_data[DATA_W-1:AMT_W]};

  shift_imm_normalize #(.AMT_W(AMT_W)) u_norm (
    .type_i (bus.instr[6:5]),
    .amt5_i (bus.instr[11:7]),
    .type_o (norm_type),
    .amt_o  (norm_amt),
    .rrx_o  (norm_rrx)
  );

  // Field decode of the instruction currently on the bus; only used at accept.
  always_comb begin
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    dec_type    = SHIFT_LSL;
    dec_amt     = '0;
    dec_rrx     = 1'b0;
    dec_ill     = 1'b0;
    dec_is_rs   = 1'b0;
    case (bus.instr[27:26])
      CLASS_DP: begin
        if (bus.instr[25]) begin
          // 8-bit immediate rotated right by twice the 4-bit rotate field
          dec_use_imm = 1'b1;
          dec_imm     = DATA_W'(bus.instr[7:0]);
          dec_type    = SHIFT_ROR;
          dec_amt     = AMT_W'({bus.instr[11:8], 1'b0});
        end else if (!bus.instr[4]) begin
          dec_type = norm_type;
          dec_amt  = norm_amt;
          dec_rrx  = norm_rrx;
        end else begin
          dec_is_rs = 1'b1;
          dec_type  = bus.instr[6:5];
        end
      end
      CLASS_SDT: begin
        // The I bit has the opposite sense here: I=0 is the 12-bit offset.
        if (!bus.instr[25]) begin
          dec_use_imm = 1'b1;
          dec_imm     = DATA_W'(bus.instr[11:0]);
        end else if (!bus.instr[4]) begin
          dec_type = norm_type;
          dec_amt  = norm_amt;
          dec_rrx  = norm_rrx;
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A new instruction may be taken in the same cycle the shifter consumes the
  // current one, so back-to-back operands see no bubble.
  assign instr_ready = (state_q == ST_IDLE) | ((state_q == ST_OUT) & bus.op_ready);
  assign accept      = bus.instr_valid & instr_ready;

  always_comb begin
    state_d   = state_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    type_d    = type_q;
    amt_d     = amt_q;
    rrx_d     = rrx_q;
    ill_d     = ill_q;
    rm_d      = rm_q;
    rs_d      = rs_q;

    case (state_q)
      ST_IDLE:   ;
      ST_RS_REQ: state_d = ST_RS_CAP;
      ST_RS_CAP: begin
        // Rs amount is used raw: 0 passes through, values >= 32 are not clamped.
        amt_d   = bus.rs_data[AMT_W-1:0];
        state_d = ST_OUT;
      end
      ST_OUT:    if (bus.op_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Accept only occurs from IDLE or a consumed OUT, so it overrides the above.
    if (accept) begin
      use_imm_d = dec_use_imm;
      imm_d     = dec_imm;
      type_d    = dec_type;
      amt_d     = dec_is_rs ? '0 : dec_amt;
      rrx_d     = dec_rrx;
      ill_d     = dec_ill;
      rm_d      = bus.instr[3:0];
      rs_d      = bus.instr[11:8];
      state_d   = dec_is_rs ? ST_RS_REQ : ST_OUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      type_q    <= SHIFT_LSL;
      amt_q     <= '0;
      rrx_q     <= 1'b0;
      ill_q     <= 1'b0;
      rm_q      <= '0;
      rs_q      <= '0;
    end else begin
      state_q   <= state_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      type_q    <= type_d;
      amt_q     <= amt_d;
      rrx_q     <= rrx_d;
      ill_q     <= ill_d;
      rm_q      <= rm_d;
      rs_q      <= rs_d;
    end
  end

  assign bus.instr_ready = instr_ready;
  assign bus.rs_read_en  = (state_q == ST_RS_REQ);
  assign bus.rs_addr     = rs_q;
  assign bus.op_valid    = (state_q == ST_OUT);
  assign bus.rm_addr     = rm_q;
  assign bus.use_imm     = use_imm_q;
  assign bus.imm_value   = imm_q;
  assign bus.shiftType   = type_q;
  assign bus.shift_amt   = amt_q;
  assign bus.rrx         = rrx_q;
  assign bus.op_illegal  = ill_q;

endmodule
